// File: rtl/logicnet_input_quantizer.sv
// LogicNet input quantizer: encodes a frame of signed raw samples into packed
// IN_BITS-wide threshold codes for the first LUT layer.
// Optional build macro LOGICNET_QUANT_STATS_EN adds frame_cnt / err_cnt outputs.
module logicnet_input_quantizer #(
  parameter int unsigned NUM_FEATURES = 8,
  parameter int unsigned FEAT_W       = 16,
  parameter int unsigned IN_BITS      = 2,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [FEAT_W-1:0]               s_data,
  input  logic                            s_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_FEATURES*IN_BITS-1:0] m_data,
  input  logic                            cfg_we,
  input  logic [ADDR_W-1:0]               cfg_addr,
  input  logic [FEAT_W-1:0]               cfg_data,
  output logic                            frame_err,
`ifdef LOGICNET_QUANT_STATS_EN
  output logic                            cfg_err,
  output logic [15:0]                     frame_cnt,
  output logic [7:0]                      err_cnt
`else
  output logic                            cfg_err
`endif
);

  localparam int unsigned NT      = (2 ** IN_BITS) - 1;
  localparam int unsigned NUM_THR = NUM_FEATURES * NT;
  localparam int unsigned IDX_W   = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned OUT_W   = NUM_FEATURES * IN_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [OUT_W-1:0]         asm_q, asm_d;
  logic [OUT_W-1:0]         mdata_q, mdata_d;
  logic                     frame_err_q, frame_err_d;
  logic                     cfg_err_q, cfg_err_d;
  logic signed [FEAT_W-1:0] thr_q [NUM_FEATURES][NT];

  logic [IN_BITS-1:0]       code;
  logic                     beat;
  logic                     last_idx;
  logic                     cfg_ok;

  assign s_ready   = (state_q == StCollect);
  assign m_valid   = (state_q == StHold);
  assign m_data    = mdata_q;
  assign frame_err = frame_err_q;
  assign cfg_err   = cfg_err_q;

  assign beat     = s_valid && s_ready;
  assign last_idx = (idx_q == LAST_IDX);
  // Thresholds may only change between frames so a frame never mixes two tables.
  assign cfg_ok   = cfg_we && (state_q == StCollect) && (idx_q == '0) &&
                    (32'(cfg_addr) < NUM_THR);

  // Code = number of thresholds of the current feature the sample meets or exceeds.
  always_comb begin
    code = '0;
    for (int k = 0; k < int'(NT); k++) begin
      if ($signed(s_data) >= thr_q[idx_q][k]) begin
        code = code + IN_BITS'(1);
      end
    end
  end

  // Frame assembly, framing checks and output handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    mdata_d     = mdata_q;
    frame_err_d = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      StCollect: begin
        if (beat) begin
          if (last_idx && s_last) begin
            mdata_d = asm_q;
            mdata_d[idx_q*IN_BITS +: IN_BITS] = code;
            state_d = StHold;
            idx_d   = '0;
          end else if (last_idx || s_last) begin
            // Frame length disagrees with s_last: drop it and resync at feature 0.
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else begin
            asm_d[idx_q*IN_BITS +: IN_BITS] = code;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StHold: begin
        if (m_ready) begin
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
    if (cfg_we && !cfg_ok) begin
      cfg_err_d = 1'b1;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      idx_q       <= '0;
      asm_q       <= '0;
      mdata_q     <= '0;
      frame_err_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      mdata_q     <= mdata_d;
      frame_err_q <= frame_err_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Threshold table; a write lands at the edge, so a same-cycle sample sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < int'(NUM_FEATURES); f++) begin
        for (int k = 0; k < int'(NT); k++) begin
          thr_q[f][k] <= '0;
        end
      end
    end else if (cfg_ok) begin
      for (int f = 0; f < int'(NUM_FEATURES); f++) begin
        for (int k = 0; k < int'(NT); k++) begin
          if (32'(cfg_addr) == (32'(f) * NT + 32'(k))) begin
            thr_q[f][k] <= cfg_data;
          end
        end
      end
    end
  end

`ifdef LOGICNET_QUANT_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

  // Delivered-frame counter wraps; error counter sticks at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (m_valid && m_ready) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (frame_err_q && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Self-checking bench for logicnet_input_quantizer with a counting reference model.
module tb_logicnet_input_quantizer;

  localparam int NF = 8;
  localparam int IB = 2;
  localparam int NT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_data;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        frame_err, cfg_err;
`ifdef LOGICNET_QUANT_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int thr_m [NF*NT];
  int samp  [NF];

  always #5 clk = ~clk;

  logicnet_input_quantizer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .frame_err (frame_err),
`ifdef LOGICNET_QUANT_STATS_EN
    .cfg_err   (cfg_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`else
    .cfg_err   (cfg_err)
`endif
  );

  // Expected packed vector: per feature, count thresholds the sample reaches.
  function automatic logic [15:0] model_vec();
    logic [15:0] v;
    int code;
    v = '0;
    for (int f = 0; f < NF; f++) begin
      code = 0;
      for (int k = 0; k < NT; k++) if (samp[f] >= thr_m[f*NT+k]) code++;
      v = v | (16'(code) << (IB*f));
    end
    return v;
  endfunction

  function automatic int rand_s16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NF*NT; i++) thr_m[i] = 0;
  endtask

  task automatic cfg_write(input int addr, input int data, output logic err);
    cfg_we   = 1'b1;
    cfg_addr = 5'(addr);
    cfg_data = 16'(data);
    tick();
    cfg_we = 1'b0;
    err    = cfg_err;
  endtask

  // Drive samp[first .. first+count-1] with random idle gaps; s_last on index last_at.
  task automatic send_beats(input int first, input int count, input int last_at);
    for (int i = first; i < first + count; i++) begin
      repeat ($urandom_range(2)) tick();
      s_valid = 1'b1;
      s_data  = 16'(samp[i]);
      s_last  = (i == last_at);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic release_out();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic rand_samples();
    for (int i = 0; i < NF; i++) samp[i] = rand_s16();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    total++; if (m_data !== 16'h0) begin bad++; $display("FAIL reset_m_data got=%h want=0000", m_data); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
  endtask

  task automatic test_quant();
    logic e;
    int   errs;
    int   tv [3];
    tv[0] = -100; tv[1] = 0; tv[2] = 100;
    errs = 0;
    for (int a = 0; a < NF*NT; a++) begin
      cfg_write(a, tv[a%NT], e);
      if (e !== 1'b0) errs++;
      thr_m[a] = tv[a%NT];
    end
    total++; if (errs != 0) begin bad++; $display("FAIL quant_cfg_accept got=%0d want=0 rejects", errs); end
    samp[0] = -200; samp[1] = -100; samp[2] = -1;    samp[3] = 0;
    samp[4] = 99;   samp[5] = 100;  samp[6] = 32767; samp[7] = -32768;
    send_beats(0, NF, NF-1);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL quant_latency got=%b want=1", m_valid); end
    // Codes {0,1,1,2,2,3,3,0}, feature 0 in the LSBs.
    total++; if (m_data !== 16'h3E94) begin bad++; $display("FAIL quant_const got=%h want=3e94", m_data); end
    total++; if (m_data !== model_vec()) begin bad++; $display("FAIL quant_model got=%h want=%h", m_data, model_vec()); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL quant_hold_s_ready got=%b want=0", s_ready); end
    release_out();
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL quant_release got=%b%b want=01", m_valid, s_ready);
    end
  endtask

  task automatic test_random_frames();
    logic e;
    int   errs;
    logic [15:0] exp;
    errs = 0;
    for (int a = 0; a < NF*NT; a++) begin
      thr_m[a] = rand_s16() / 4;
      cfg_write(a, thr_m[a], e);
      if (e !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL rand_cfg_accept got=%0d want=0 rejects", errs); end
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NF; i++) samp[i] = ($urandom_range(3) == 0) ? rand_s16() : rand_s16() / 4;
      exp = model_vec();
      send_beats(0, NF, NF-1);
      repeat ($urandom_range(3)) tick();
      total++; if (m_valid !== 1'b1 || m_data !== exp) begin
        bad++; $display("FAIL rand_frame%0d got=%b/%h want=1/%h", n, m_valid, m_data, exp);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    int errs;
    rand_samples();
    exp = model_vec();
    send_beats(0, NF, NF-1);
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      // Offered beats during HOLD must be ignored.
      s_valid = 1'b1; s_data = 16'($urandom); s_last = 1'($urandom);
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== exp) errs++;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold got=%0d want=0 bad cycles", errs); end
    total++; if (m_data !== exp) begin bad++; $display("FAIL bp_data got=%h want=%h", m_data, exp); end
    release_out();
    total++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got=%b%b want=10", s_ready, m_valid);
    end
    rand_samples();
    exp = model_vec();
    send_beats(0, NF, NF-1);
    total++; if (m_valid !== 1'b1 || m_data !== exp) begin
      bad++; $display("FAIL bp_second got=%b/%h want=1/%h", m_valid, m_data, exp);
    end
    release_out();
  endtask

  task automatic test_early_last();
    logic [15:0] exp;
    rand_samples();
    send_beats(0, 5, 4);
    total++; if (frame_err !== 1'b1 || m_valid !== 1'b0) begin
      bad++; $display("FAIL early_err got=%b%b want=10", frame_err, m_valid);
    end
    tick();
    total++; if (frame_err !== 1'b0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL early_pulse got=%b%b want=00", frame_err, m_valid);
    end
    rand_samples();
    exp = model_vec();
    send_beats(0, NF, NF-1);
    total++; if (m_valid !== 1'b1 || m_data !== exp) begin
      bad++; $display("FAIL early_next got=%b/%h want=1/%h", m_valid, m_data, exp);
    end
    release_out();
  endtask

  task automatic test_missing_last();
    logic [15:0] exp;
    rand_samples();
    send_beats(0, NF, -1);
    total++; if (frame_err !== 1'b1 || m_valid !== 1'b0) begin
      bad++; $display("FAIL miss_err got=%b%b want=10", frame_err, m_valid);
    end
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL miss_dropped got=%b want=0", m_valid); end
    rand_samples();
    exp = model_vec();
    send_beats(0, NF, NF-1);
    total++; if (m_valid !== 1'b1 || m_data !== exp) begin
      bad++; $display("FAIL miss_next got=%b/%h want=1/%h", m_valid, m_data, exp);
    end
    release_out();
  endtask

  task automatic test_cfg_reject();
    logic e;
    logic [15:0] exp;
    rand_samples();
    exp = model_vec();
    send_beats(0, 3, -1);
    cfg_write(5, 16'h1234, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL cfg_midframe got=%b want=1", e); end
    send_beats(3, NF-3, NF-1);
    total++; if (m_valid !== 1'b1 || m_data !== exp) begin
      bad++; $display("FAIL cfg_midframe_frame got=%b/%h want=1/%h", m_valid, m_data, exp);
    end
    cfg_write(0, -32768, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL cfg_hold got=%b want=1", e); end
    total++; if (m_valid !== 1'b1 || m_data !== exp) begin
      bad++; $display("FAIL cfg_hold_data got=%b/%h want=1/%h", m_valid, m_data, exp);
    end
    release_out();
    cfg_write(24, 0, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL cfg_addr24 got=%b want=1", e); end
    cfg_write(31, 0, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL cfg_addr31 got=%b want=1", e); end
    tick();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse got=%b want=0", cfg_err); end
    rand_samples();
    exp = model_vec();
    send_beats(0, NF, NF-1);
    total++; if (m_valid !== 1'b1 || m_data !== exp) begin
      bad++; $display("FAIL cfg_unchanged got=%b/%h want=1/%h", m_valid, m_data, exp);
    end
    release_out();
  endtask

  task automatic test_cfg_same_cycle();
    logic e;
    logic [15:0] exp;
    thr_m[0] = -100; cfg_write(0, -100, e);
    thr_m[1] = 0;    cfg_write(1, 0, e);
    thr_m[2] = 100;  cfg_write(2, 100, e);
    rand_samples();
    samp[0] = 50;
    exp = model_vec();
    s_valid = 1'b1; s_data = 16'(samp[0]); s_last = 1'b0;
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'(200);
    tick();
    s_valid = 1'b0; cfg_we = 1'b0;
    thr_m[0] = 200;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL same_cfg_err got=%b want=0", cfg_err); end
    send_beats(1, NF-1, NF-1);
    total++; if (m_valid !== 1'b1 || m_data !== exp) begin
      bad++; $display("FAIL same_old_thr got=%b/%h want=1/%h", m_valid, m_data, exp);
    end
    release_out();
    exp = model_vec();
    send_beats(0, NF, NF-1);
    total++; if (m_data[1:0] !== 2'd1 || m_data !== exp) begin
      bad++; $display("FAIL same_new_thr got=%h want=%h", m_data, exp);
    end
    release_out();
  endtask

  task automatic test_reset_midframe();
    rand_samples();
    send_beats(0, 4, -1);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NF*NT; i++) thr_m[i] = 0;
    total++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'h0) begin
      bad++; $display("FAIL rst_mid got=%b%b/%h want=10/0000", s_ready, m_valid, m_data);
    end
    for (int i = 0; i < NF; i++) samp[i] = 0;
    send_beats(0, NF, NF-1);
    total++; if (m_valid !== 1'b1 || m_data !== 16'hFFFF) begin
      bad++; $display("FAIL rst_zero_frame got=%b/%h want=1/ffff", m_valid, m_data);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'h0) begin
      bad++; $display("FAIL rst_hold got=%b%b/%h want=10/0000", s_ready, m_valid, m_data);
    end
  endtask

`ifdef LOGICNET_QUANT_STATS_EN
  task automatic test_stats();
    do_reset();
    total++; if (frame_cnt !== 16'd0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL stats_reset got=%0d/%0d want=0/0", frame_cnt, err_cnt);
    end
    for (int n = 0; n < 3; n++) begin
      rand_samples();
      send_beats(0, NF, NF-1);
      release_out();
    end
    total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL stats_frames got=%0d want=3", frame_cnt); end
    for (int n = 0; n < 300; n++) begin
      samp[0] = rand_s16();
      send_beats(0, 1, 0);
      if (n == 9) begin
        tick();
        total++; if (err_cnt !== 8'd10) begin bad++; $display("FAIL stats_err10 got=%0d want=10", err_cnt); end
      end
    end
    tick(); tick();
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL stats_err_sat got=%0d want=255", err_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    for (int i = 0; i < NF; i++) samp[i] = 0;
    test_reset();
    test_quant();
    test_random_frames();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_cfg_reject();
    test_cfg_same_cycle();
    test_reset_midframe();
`ifdef LOGICNET_QUANT_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
